// File: rtl/ef_tmr32_seq_pkg.sv
// Shared types for the timer/PWM profile sequencer.
// State encodings and table entry field widths.
package ef_tmr32_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } seq_state_e;

  localparam int TW  = 32;
  localparam int CFW = 3 * TW;

endpackage

// File: rtl/ef_tmr32_seq_rf.sv
// Profile table: DEPTH entries, one write port,
// one asynchronous read port. Contents are not reset.
import ef_tmr32_seq_pkg::*;

module ef_tmr32_seq_rf #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int RW    = 16
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [CFW+RW-1:0]   i_wdata,
  input  logic [AW-1:0]       i_raddr,
  output logic [CFW+RW-1:0]   o_rdata
);

  logic [CFW+RW-1:0] r_mem [DEPTH];

  // entry write
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ef_tmr32_pwm_seq.sv
// PWM profile sequencer: steps a table of timer settings,
// advancing once per completed timer period.
import ef_tmr32_seq_pkg::*;

module ef_tmr32_pwm_seq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int RW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [31:0]   cfg_reload,
  input  logic [31:0]   cfg_cmpx,
  input  logic [31:0]   cfg_cmpy,
  input  logic [RW-1:0] cfg_rpt,
  input  logic [AW-1:0] seq_last,
  input  logic          seq_loop,
  input  logic          start,
  input  logic          stop,
  input  logic          timeout_flag,
  output logic          tmr_en,
  output logic [31:0]   tmr_reload,
  output logic [31:0]   cmpx,
  output logic [31:0]   cmpy,
  output logic          busy,
  output logic [AW-1:0] cur_idx,
  output logic          done
);

  seq_state_e          r_state;
  seq_state_e          w_state_nxt;
  logic                r_flag_q;
  logic [RW-1:0]       r_rpt_cnt;
  logic                r_tmr_en;
  logic                r_done;
  logic [31:0]         r_reload;
  logic [31:0]         r_cmpx;
  logic [31:0]         r_cmpy;
  logic [AW-1:0]       r_cur_idx;

  logic                w_to_edge;
  logic                w_at_last;
  logic                w_load;
  logic                w_dec;
  logic [AW-1:0]       w_ld_idx;
  logic [CFW+RW-1:0]   w_wdata;
  logic [CFW+RW-1:0]   w_rdata;

  assign w_wdata   = {cfg_rpt, cfg_cmpy, cfg_cmpx, cfg_reload};
  assign w_to_edge = timeout_flag & ~r_flag_q;
  assign w_at_last = (r_cur_idx == seq_last);

  ef_tmr32_seq_rf #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .RW    (RW)
  ) u_rf (
    .clk     (clk),
    .i_we    (cfg_we),
    .i_waddr (cfg_addr),
    .i_wdata (w_wdata),
    .i_raddr (w_ld_idx),
    .o_rdata (w_rdata)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next state, entry load and repeat decrement decisions
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_ld_idx    = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ARM;
          w_load      = 1'b1;
        end
      end
      S_ARM: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_to_edge) begin
          if (r_rpt_cnt != '0) begin
            w_dec = 1'b1;
          end else if (w_at_last && !seq_loop) begin
            w_state_nxt = S_DONE;
          end else begin
            w_load   = 1'b1;
            w_ld_idx = w_at_last ? '0 : r_cur_idx + 1'b1;
          end
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (stop) begin
      w_state_nxt = S_IDLE;
      w_load      = 1'b0;
      w_dec       = 1'b0;
    end
  end

  // timer-facing registers, repeat counter and edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_q  <= 1'b0;
      r_rpt_cnt <= '0;
      r_tmr_en  <= 1'b0;
      r_done    <= 1'b0;
      r_reload  <= '0;
      r_cmpx    <= '0;
      r_cmpy    <= '0;
      r_cur_idx <= '0;
    end else begin
      r_flag_q <= timeout_flag;
      if (w_load) begin
        r_reload  <= w_rdata[0 +: 32];
        r_cmpx    <= w_rdata[32 +: 32];
        r_cmpy    <= w_rdata[64 +: 32];
        r_rpt_cnt <= w_rdata[CFW +: RW];
        r_cur_idx <= w_ld_idx;
      end else if (w_dec) begin
        r_rpt_cnt <= r_rpt_cnt - 1'b1;
      end
      r_done <= (r_state == S_DONE) && !stop;
      if (stop)                    r_tmr_en <= 1'b0;
      else if (r_state == S_ARM)   r_tmr_en <= 1'b1;
      else if (r_state == S_DONE)  r_tmr_en <= 1'b0;
    end
  end

  assign tmr_en     = r_tmr_en;
  assign tmr_reload = r_reload;
  assign cmpx       = r_cmpx;
  assign cmpy       = r_cmpy;
  assign cur_idx    = r_cur_idx;
  assign done       = r_done;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ef_tmr32_pwm_seq.sv
// Self-checking bench for the PWM profile sequencer.
// A reference model pushes expected entries per timer period.
module tb_ef_tmr32_pwm_seq;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int RW    = 16;

  logic          clk;
  logic          rst;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [31:0]   cfg_reload;
  logic [31:0]   cfg_cmpx;
  logic [31:0]   cfg_cmpy;
  logic [RW-1:0] cfg_rpt;
  logic [AW-1:0] seq_last;
  logic          seq_loop;
  logic          start;
  logic          stop;
  logic          timeout_flag;
  logic          tmr_en;
  logic [31:0]   tmr_reload;
  logic [31:0]   cmpx;
  logic [31:0]   cmpy;
  logic          busy;
  logic [AW-1:0] cur_idx;
  logic          done;

  typedef struct {
    logic [AW-1:0] idx;
    logic [31:0]   rl;
    logic [31:0]   cx;
    logic [31:0]   cy;
    logic          busy;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  exp_t m_cur;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]   m_rl  [DEPTH];
  logic [31:0]   m_cx  [DEPTH];
  logic [31:0]   m_cy  [DEPTH];
  logic [RW-1:0] m_rpt [DEPTH];
  int            m_idx;
  int            m_cnt;
  bit            m_busy;

  ef_tmr32_pwm_seq #(.DEPTH(DEPTH), .AW(AW), .RW(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_reload   (cfg_reload),
    .cfg_cmpx     (cfg_cmpx),
    .cfg_cmpy     (cfg_cmpy),
    .cfg_rpt      (cfg_rpt),
    .seq_last     (seq_last),
    .seq_loop     (seq_loop),
    .start        (start),
    .stop         (stop),
    .timeout_flag (timeout_flag),
    .tmr_en       (tmr_en),
    .tmr_reload   (tmr_reload),
    .cmpx         (cmpx),
    .cmpy         (cmpy),
    .busy         (busy),
    .cur_idx      (cur_idx),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic m_load(input int i);
    m_idx      = i;
    m_cnt      = int'(m_rpt[i]);
    m_cur.idx  = i[AW-1:0];
    m_cur.rl   = m_rl[i];
    m_cur.cx   = m_cx[i];
    m_cur.cy   = m_cy[i];
  endtask

  task automatic wr(input int a, input logic [31:0] rl,
                    input logic [31:0] cx, input logic [31:0] cy,
                    input logic [RW-1:0] r);
    cfg_we     = 1'b1;
    cfg_addr   = a[AW-1:0];
    cfg_reload = rl;
    cfg_cmpx   = cx;
    cfg_cmpy   = cy;
    cfg_rpt    = r;
    tick();
    cfg_we     = 1'b0;
    m_rl[a]    = rl;
    m_cx[a]    = cx;
    m_cy[a]    = cy;
    m_rpt[a]   = r;
  endtask

  task automatic go;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_load(0);
    m_busy = 1'b1;
    m_cur.busy = 1'b1;
  endtask

  task automatic halt;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    m_busy = 1'b0;
  endtask

  // one timer period: flag high for hold cycles, then low
  task automatic period(input int hold);
    timeout_flag = 1'b1;
    repeat (hold) tick();
    timeout_flag = 1'b0;
    tick();
    if (m_busy) begin
      if (m_cnt != 0) m_cnt--;
      else if (m_idx == int'(seq_last) && !seq_loop) m_busy = 1'b0;
      else m_load((m_idx == int'(seq_last)) ? 0 : m_idx + 1);
    end
    m_cur.busy = m_busy;
    sb.push_back(m_cur);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    n_vec++;
    if (tmr_en !== 1'b0 || tmr_reload !== 32'd0 || cmpx !== 32'd0 ||
        cmpy !== 32'd0 || busy !== 1'b0 || cur_idx !== '0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: en=%b rl=%0d cx=%0d cy=%0d busy=%b idx=%0d done=%b, want all 0",
               tmr_en, tmr_reload, cmpx, cmpy, busy, cur_idx, done);
    end
  endtask

  task automatic test_once;
    seq_last = 1;
    seq_loop = 0;
    go();
    n_vec++;
    if (tmr_reload !== 32'd100 || cmpx !== 32'd25 || cmpy !== 32'd50 ||
        cur_idx !== 0 || tmr_en !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL once_load: rl=%0d cx=%0d cy=%0d idx=%0d en=%b busy=%b, want 100 25 50 0 0 1",
               tmr_reload, cmpx, cmpy, cur_idx, tmr_en, busy);
    end
    tick();
    n_vec++;
    if (tmr_en !== 1'b1) begin
      n_err++;
      $display("FAIL once_en: tmr_en=%b, want 1", tmr_en);
    end
    for (int k = 0; k < 3; k++) begin
      period(1);
      e = sb.pop_front();
      n_vec++;
      if (cur_idx !== e.idx || tmr_reload !== e.rl || cmpx !== e.cx ||
          cmpy !== e.cy || busy !== e.busy) begin
        n_err++;
        $display("FAIL once_p%0d: idx=%0d rl=%0d cx=%0d cy=%0d busy=%b, want %0d %0d %0d %0d %b",
                 k, cur_idx, tmr_reload, cmpx, cmpy, busy,
                 e.idx, e.rl, e.cx, e.cy, e.busy);
      end
    end
    n_vec++;
    if (done !== 1'b1 || tmr_en !== 1'b0) begin
      n_err++;
      $display("FAIL once_done: done=%b en=%b, want 1 0", done, tmr_en);
    end
    tick();
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL once_done_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_loop(input int hold, input int n);
    seq_last = 1;
    seq_loop = 1;
    go();
    tick();
    for (int k = 0; k < n; k++) begin
      period(hold);
      e = sb.pop_front();
      n_vec++;
      if (cur_idx !== e.idx || tmr_reload !== e.rl || cmpy !== e.cy ||
          busy !== e.busy || done !== 1'b0 || tmr_en !== 1'b1) begin
        n_err++;
        $display("FAIL loop_h%0d_p%0d: idx=%0d rl=%0d cy=%0d busy=%b done=%b en=%b, want %0d %0d %0d %b 0 1",
                 hold, k, cur_idx, tmr_reload, cmpy, busy, done, tmr_en,
                 e.idx, e.rl, e.cy, e.busy);
      end
    end
    halt();
    n_vec++;
    if (busy !== 1'b0 || tmr_en !== 1'b0) begin
      n_err++;
      $display("FAIL loop_stop: busy=%b en=%b, want 0 0", busy, tmr_en);
    end
  endtask

  task automatic test_stop;
    seq_last = 1;
    seq_loop = 0;
    go();
    tick();
    halt();
    n_vec++;
    if (busy !== 1'b0 || tmr_en !== 1'b0 || done !== 1'b0 ||
        tmr_reload !== 32'd100 || cur_idx !== 0) begin
      n_err++;
      $display("FAIL stop_run: busy=%b en=%b done=%b rl=%0d idx=%0d, want 0 0 0 100 0",
               busy, tmr_en, done, tmr_reload, cur_idx);
    end
    tick();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL stop_nodone: done=%b busy=%b, want 0 0", done, busy);
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();
    n_vec++;
    if (busy !== 1'b0 || tmr_en !== 1'b0) begin
      n_err++;
      $display("FAIL stop_start_same: busy=%b en=%b, want 0 0", busy, tmr_en);
    end
  endtask

  task automatic test_busy_start_and_write;
    seq_last = 1;
    seq_loop = 0;
    go();
    tick();
    period(1);
    e = sb.pop_front();
    n_vec++;
    if (cur_idx !== e.idx || tmr_reload !== e.rl || busy !== e.busy) begin
      n_err++;
      $display("FAIL busy_p0: idx=%0d rl=%0d busy=%b, want %0d %0d %b",
               cur_idx, tmr_reload, busy, e.idx, e.rl, e.busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || tmr_en !== 1'b1 || cur_idx !== 0) begin
      n_err++;
      $display("FAIL busy_start: busy=%b en=%b idx=%0d, want 1 1 0", busy, tmr_en, cur_idx);
    end
    wr(1, 32'd300, 32'd75, 32'd225, 16'd0);
    for (int k = 1; k < 3; k++) begin
      period(1);
      e = sb.pop_front();
      n_vec++;
      if (cur_idx !== e.idx || tmr_reload !== e.rl || cmpx !== e.cx ||
          cmpy !== e.cy || busy !== e.busy) begin
        n_err++;
        $display("FAIL busy_p%0d: idx=%0d rl=%0d cx=%0d cy=%0d busy=%b, want %0d %0d %0d %0d %b",
                 k, cur_idx, tmr_reload, cmpx, cmpy, busy,
                 e.idx, e.rl, e.cx, e.cy, e.busy);
      end
    end
    tick();
  endtask

  task automatic test_rst_and_single;
    seq_last = 1;
    seq_loop = 1;
    go();
    tick();
    period(1);
    void'(sb.pop_front());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_busy = 1'b0;
    n_vec++;
    if (tmr_en !== 1'b0 || tmr_reload !== 32'd0 || cmpx !== 32'd0 ||
        cmpy !== 32'd0 || busy !== 1'b0 || cur_idx !== '0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_run: en=%b rl=%0d cx=%0d cy=%0d busy=%b idx=%0d done=%b, want all 0",
               tmr_en, tmr_reload, cmpx, cmpy, busy, cur_idx, done);
    end
    wr(0, 32'd100, 32'd25, 32'd50, 16'd0);
    seq_last = 0;
    seq_loop = 1;
    go();
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 1) wr(0, 32'd111, 32'd30, 32'd60, 16'd0);
      period(1);
      e = sb.pop_front();
      n_vec++;
      if (cur_idx !== e.idx || tmr_reload !== e.rl || cmpx !== e.cx ||
          cmpy !== e.cy || busy !== e.busy) begin
        n_err++;
        $display("FAIL single_p%0d: idx=%0d rl=%0d cx=%0d cy=%0d busy=%b, want %0d %0d %0d %0d %b",
                 k, cur_idx, tmr_reload, cmpx, cmpy, busy,
                 e.idx, e.rl, e.cx, e.cy, e.busy);
      end
    end
    halt();
  endtask

  initial begin
    rst          = 1'b0;
    cfg_we       = 1'b0;
    cfg_addr     = '0;
    cfg_reload   = '0;
    cfg_cmpx     = '0;
    cfg_cmpy     = '0;
    cfg_rpt      = '0;
    seq_last     = '0;
    seq_loop     = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    timeout_flag = 1'b0;
    m_busy       = 1'b0;
    m_idx        = 0;
    m_cnt        = 0;
    m_cur        = '{idx: '0, rl: '0, cx: '0, cy: '0, busy: 1'b0};
    test_reset();
    wr(0, 32'd100, 32'd25, 32'd50, 16'd1);
    wr(1, 32'd200, 32'd50, 32'd150, 16'd0);
    test_once();
    test_loop(1, 6);
    test_loop(4, 5);
    test_stop();
    test_busy_start_and_write();
    wr(1, 32'd200, 32'd50, 32'd150, 16'd0);
    test_rst_and_single();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
